// File: rtl/mdu_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit.
// Opcode and FSM state types plus small opcode helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply
// or restoring shift-subtract divide, purely combinational.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] opa_nxt
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;

    // Compute both iteration flavours and select by op class
    always_comb begin
        addend  = opa[0] ? opb : {WIDTH{1'b0}};
        sum     = {1'b0, acc} + {1'b0, addend};
        shl     = {acc, opa[WIDTH-1]};
        diff    = shl - {1'b0, opb};
        acc_nxt = acc;
        opa_nxt = opa;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                opa_nxt = {opa[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shl[WIDTH-1:0];
                opa_nxt = {opa[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[WIDTH:1];
            opa_nxt = {sum[0], opa[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multi-cycle multiply/divide unit with HI/LO,
// MTHI/MTLO writes and a pipeline stall request.
module exe_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_rd,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e       state;
    mdu_state_e       state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             is_div_q;
    logic             neg_lo;
    logic             neg_hi;
    logic             div0;

    logic             sgn;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] opa_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc     (acc),
        .opa     (opa),
        .opb     (opb),
        .acc_nxt (acc_nxt),
        .opa_nxt (opa_nxt)
    );

    // Operand magnitudes for signed ops, taken at start
    always_comb begin
        sgn    = op_is_signed(op);
        rs_neg = sgn & rs_data[WIDTH-1];
        rt_neg = sgn & rt_data[WIDTH-1];
        rs_abs = rs_neg ? -rs_data : rs_data;
        rt_abs = rt_neg ? -rt_data : rt_data;
    end

    // Sign fixup of the unsigned result; divide by zero forces lo to ones
    always_comb begin
        prod     = {acc, opa};
        prod_fix = neg_lo ? -prod : prod;
        if (is_div_q) begin
            fix_lo = div0 ? {WIDTH{1'b1}} : (neg_lo ? -opa : opa);
            fix_hi = neg_hi ? -acc : acc;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state; flush returns to idle from anywhere
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_RUN;
                ST_RUN:  if (count == LAST) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy and the pipeline stall request
    always_comb begin
        busy  = (state != ST_IDLE);
        stall = busy & (start | hilo_rd | hi_we | lo_we);
    end

    // Datapath, counter and HI/LO registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            is_div_q <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            acc      <= '0;
                            opa      <= rs_abs;
                            opb      <= rt_abs;
                            count    <= '0;
                            is_div_q <= op_is_div(op);
                            neg_lo   <= rs_neg ^ rt_neg;
                            neg_hi   <= rs_neg;
                            div0     <= (rt_data == '0);
                        end else begin
                            if (hi_we) hi <= wdata;
                            if (lo_we) lo <= wdata;
                        end
                    end
                    ST_RUN: begin
                        acc   <= acc_nxt;
                        opa   <= opa_nxt;
                        count <= count + 1'b1;
                    end
                    ST_FIX: begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: directed ops queue
// expected {hi,lo}; a negedge monitor checks each done pulse.
module tb_exe_muldiv_unit;

    logic        clock = 0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hilo_rd;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    logic [63:0] exp_q[$];

    exe_muldiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hilo_rd (hilo_rd),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .flush   (flush),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result
    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hilo", {hi, lo}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el);
        int n;
        exp_q.push_back({eh, el});
        op = o;
        rs_data = a;
        rt_data = b;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("latency_edges", 64'(n + 1), 64'd34);
    endtask

    initial begin
        int n;
        int ds;
        reset = 1;
        start = 0;
        op = 0;
        rs_data = 0;
        rt_data = 0;
        hilo_rd = 0;
        hi_we = 0;
        lo_we = 0;
        wdata = 0;
        flush = 0;
        repeat (3) tick();
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_flags", {61'd0, busy, done, stall}, 64'd0);
        reset = 0;
        tick();

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        do_op(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        do_op(2'b00, 32'h00010000, 32'h00010000, 32'd1, 32'd0);
        tick();

        // Dependent MFHI held behind an in-flight op
        exp_q.push_back({32'd0, 32'd15});
        op = 2'b01;
        rs_data = 3;
        rt_data = 5;
        start = 1;
        tick();
        start = 0;
        hilo_rd = 1;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            check("stall_busy", 64'(stall), 64'd1);
            tick();
            n++;
        end
        check("stall_done_cycle", {62'd0, done, stall}, 64'd2);
        hilo_rd = 0;
        tick();

        // Flush mid-run after MTHI/MTLO
        hi_we = 1;
        lo_we = 1;
        wdata = 5;
        tick();
        lo_we = 0;
        hi_we = 0;
        lo_we = 1;
        wdata = 9;
        tick();
        lo_we = 0;
        check("mthi", 64'(hi), 64'd5);
        check("mtlo", 64'(lo), 64'd9);
        op = 2'b01;
        rs_data = 7;
        rt_data = 7;
        start = 1;
        tick();
        start = 0;
        repeat (10) tick();
        ds = done_seen;
        flush = 1;
        tick();
        flush = 0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hilo", {hi, lo}, {32'd5, 32'd9});
        repeat (40) tick();
        check("flush_no_done", 64'(done_seen - ds), 64'd0);
        check("flush_hilo_kept", {hi, lo}, {32'd5, 32'd9});

        // Reset mid-run, then MTLO while idle
        op = 2'b11;
        rs_data = 1000;
        rt_data = 3;
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_flags", {62'd0, busy, done}, 64'd0);
        lo_we = 1;
        wdata = 32'h1234;
        tick();
        lo_we = 0;
        check("mtlo_after_reset", {hi, lo}, {32'd0, 32'h1234});

        repeat (40) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
